mux_arbiter: RTL

Two-requester round-robin arbiter that owns the select line of the shared 2:1 mux and registers the selected data. Each requester holds `req` for as long as it needs the mux. The arbiter issues a one-hot grant, drives `s`, and presents the granted input on a registered output with a valid flag. A hold limit stops one requester from starving the other.

---
 rtl/mux_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - two-requester round-robin arbiter owning a 2:1 mux select
// Grants are decoded straight from the state register; the selected leg is registered into out.
module mux_arbiter #(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  output logic [1:0]        gnt,
  output logic              s,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              busy
);

  localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  out_q, out_d;
  logic               out_valid_q, out_valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        case (req)
          2'b01:   state_d = GNT0;
          2'b10:   state_d = GNT1;
          2'b11:   state_d = last_q ? GNT0 : GNT1;
          default: state_d = IDLE;
        endcase
      end
      GNT0: begin
        // A release outranks preemption, so the other side gets a bubble-free hand-off
        if (!req[0])                             state_d = req[1] ? GNT1 : IDLE;
        else if (req[1] && (cnt_q == CNT_MAX))   state_d = GNT1;
      end
      GNT1: begin
        if (!req[1])                             state_d = req[0] ? GNT0 : IDLE;
        else if (req[0] && (cnt_q == CNT_MAX))   state_d = GNT0;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d == GNT0)      last_d = 1'b0;
      else if (state_d == GNT1) last_d = 1'b1;
    end else if ((state_q != IDLE) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end

    // Capture only while the current holder is still requesting
    if ((state_q == GNT0) && req[0]) begin
      out_valid_d = 1'b1;
      out_d       = in0;
    end else if ((state_q == GNT1) && req[1]) begin
      out_valid_d = 1'b1;
      out_d       = in1;
    end
  end

  assign gnt       = state_q;
  assign s         = (state_q == GNT1);
  assign busy      = |state_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule
